// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch unit.
package if_pkg;

  localparam int PC_W   = 32;
  localparam int INST_W = 32;
  localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

  // One buffered fetch result handed to decode.
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  // Force an address onto a word boundary.
  function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] a);
    return a & {{(PC_W-2){1'b1}}, 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_buf.sv
// Small show-ahead FIFO holding fetched {pc, inst} pairs for decode.
// The head entry is visible combinationally; flush empties it in one cycle.
module if_fetch_buf
  import if_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  input  logic             flush,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] cnt_reg;

  // Pointer increment with wrap for any depth, not just powers of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Entry storage; contents need no reset because occupancy qualifies them.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers and occupancy; flush takes priority over push/pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      case ({push, pop})
        2'b10:   cnt_reg <= cnt_reg + 1'b1;
        2'b01:   cnt_reg <= cnt_reg - 1'b1;
        default: cnt_reg <= cnt_reg;
      endcase
    end
  end

  assign head = mem[rd_ptr_reg];
  assign cnt  = cnt_reg;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch initiator: walks sequential PCs, issues one word read
// per cycle to instruction memory, buffers returned words and hands them to
// decode over valid/ready. A redirect flushes buffered and in-flight fetches.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int              BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic [PC_W-1:0]   im_addr,
  output logic              im_ren,
  input  logic [INST_W-1:0] im_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [PC_W-1:0]   inst_pc,
  output logic [INST_W-1:0] inst
);

  localparam int                CNT_W       = $clog2(BUF_DEPTH + 1);
  localparam logic [CNT_W:0]    DEPTH_C     = BUF_DEPTH[CNT_W:0];
  localparam logic [PC_W-1:0]   RESET_PC_AL = word_align(RESET_PC);

  fetch_state_e     state_reg;
  logic [PC_W-1:0]  pc_reg;
  logic [PC_W-1:0]  pend_pc_reg;
  logic             pend_reg;
  logic             drop_reg;

  logic             issue;
  logic             issue_state;
  logic             push;
  logic             pop;
  logic [CNT_W:0]   occ;
  logic [CNT_W-1:0] buf_cnt;
  fetch_entry_t     head;
  fetch_entry_t     push_entry;

  // FLUSH may issue too, so the new stream's first request leaves one
  // cycle after the redirect.
  assign issue_state = fetch_en && ((state_reg == RUN) || (state_reg == FLUSH));

  // Occupancy after this cycle counting the in-flight word; a new request
  // is only made when its response is guaranteed a slot.
  assign occ   = {1'b0, buf_cnt} + {{CNT_W{1'b0}}, pend_reg} - {{CNT_W{1'b0}}, pop};
  assign issue = issue_state && !redirect_valid && (occ < DEPTH_C);

  // Head is hidden during the redirect cycle so decode never takes a stale word.
  assign inst_valid = (buf_cnt != '0) && !redirect_valid;
  assign pop        = inst_valid && inst_ready;
  assign push       = pend_reg && !drop_reg && !redirect_valid;
  assign push_entry = {pend_pc_reg, im_rdata};

  assign im_ren  = issue;
  assign im_addr = word_align(pc_reg);
  assign inst_pc = inst_valid ? head.pc   : '0;
  assign inst    = inst_valid ? head.inst : '0;

  // Fetch sequencer: redirect always wins and forces a one-cycle FLUSH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else if (redirect_valid) begin
      state_reg <= FLUSH;
    end else begin
      case (state_reg)
        IDLE:    state_reg <= fetch_en ? RUN : IDLE;
        RUN:     state_reg <= fetch_en ? RUN : IDLE;
        FLUSH:   state_reg <= fetch_en ? RUN : IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // PC, pending-request tracking and discard flag for in-flight responses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_reg      <= RESET_PC_AL;
      pend_reg    <= 1'b0;
      pend_pc_reg <= '0;
      drop_reg    <= 1'b0;
    end else begin
      pend_reg <= issue;
      drop_reg <= redirect_valid && pend_reg;
      if (redirect_valid) begin
        pc_reg <= word_align(redirect_pc);
      end else if (issue) begin
        pc_reg      <= pc_reg + 32'd4;
        pend_pc_reg <= pc_reg;
      end
    end
  end

  if_fetch_buf #(
    .DEPTH (BUF_DEPTH),
    .CNT_W (CNT_W)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .cnt       (buf_cnt)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Testbench for if_fetch_unit: directed scenarios followed by random
// traffic, checked against a stream-level reference model.
module tb_if_fetch_unit;
  import if_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          DEPTH  = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] im_addr;
  logic        im_ren;
  logic [31:0] im_rdata = 32'hDEAD_BEEF;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_pc;
  logic [31:0] inst;

  int checks_cnt = 0;
  int errors_cnt = 0;

  // Reference model: next expected delivered PC, next expected request
  // address, and words requested but not yet delivered in this stream.
  logic [31:0] exp_pc;
  logic [31:0] exp_req;
  int          outstanding;
  int          pops;

  always #5 clk = ~clk;

  if_fetch_unit #(
    .RESET_PC  (RST_PC),
    .BUF_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .im_addr        (im_addr),
    .im_ren         (im_ren),
    .im_rdata       (im_rdata),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_pc        (inst_pc),
    .inst           (inst)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  // Instruction memory: one-cycle read latency, holds data when not read.
  always @(posedge clk) begin
    if (im_ren) im_rdata <= mem_word(im_addr);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Stream monitor: every request and every delivery against the model.
  initial begin
    exp_pc = RST_PC; exp_req = RST_PC; outstanding = 0; pops = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        check_eq("rst_ren", im_ren, 0);
        check_eq("rst_valid", inst_valid, 0);
        check_eq("rst_inst", inst, 0);
        check_eq("rst_inst_pc", inst_pc, 0);
        check_eq("rst_addr", im_addr, RST_PC);
        exp_pc = RST_PC; exp_req = RST_PC; outstanding = 0;
      end else if (redirect_valid) begin
        check_eq("redir_valid_mask", inst_valid, 0);
        check_eq("redir_no_ren", im_ren, 0);
        exp_pc = redirect_pc & 32'hFFFF_FFFC;
        exp_req = exp_pc;
        outstanding = 0;
      end else begin
        check_eq("addr_align", {30'd0, im_addr[1:0]}, 0);
        if (!fetch_en) check_eq("en_low_ren", im_ren, 0);
        if (im_ren) begin
          check_eq("req_addr", im_addr, exp_req);
          exp_req = exp_req + 32'd4;
          outstanding++;
        end
        if (inst_valid && inst_ready) begin
          $display("DELIVER pc=%h inst=%h", inst_pc, inst);
          check_eq("pop_pc", inst_pc, exp_pc);
          check_eq("pop_inst", inst, mem_word(exp_pc));
          exp_pc = exp_pc + 32'd4;
          outstanding--;
          pops++;
        end
        check_eq("occupancy_le_depth", {31'd0, outstanding <= DEPTH}, 1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    int   pops_start;

    reset = 1'b0; fetch_en = 1'b1; inst_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    repeat (3) next_cycle();
    reset = 1'b1;

    // Startup latency and gapless streaming.
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      sample();
      if (im_ren) found = 1'b1;
      else next_cycle();
    end
    check_eq("first_ren_seen", {31'd0, found}, 1);
    check_eq("first_ren_addr", im_addr, RST_PC);
    check_eq("first_ren_no_valid", inst_valid, 0);
    next_cycle(); sample();
    check_eq("second_ren", im_ren, 1);
    check_eq("second_addr", im_addr, 32'h4);
    check_eq("no_valid_yet", inst_valid, 0);
    next_cycle(); sample();
    check_eq("first_valid", inst_valid, 1);
    check_eq("first_pc", inst_pc, 32'h0);
    check_eq("first_inst", inst, 32'h1000_0000);
    for (int k = 1; k < 4; k++) begin
      next_cycle(); sample();
      check_eq("stream_valid", inst_valid, 1);
      check_eq("stream_pc", inst_pc, k * 4);
    end

    // Decode stall: buffer fills, requests stop, order kept on resume.
    next_cycle();
    inst_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      sample();
      check_eq("stall_ren", im_ren, 0);
      check_eq("stall_valid", inst_valid, 1);
      check_eq("stall_head", inst_pc, 32'h10);
      next_cycle();
    end
    inst_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sample();
      check_eq("resume_valid", inst_valid, 1);
      check_eq("resume_pc", inst_pc, 32'h10 + k * 4);
      next_cycle();
    end

    // Redirect with a request in flight.
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0203;
    sample();
    next_cycle(); redirect_valid = 1'b0;
    sample();
    check_eq("post_redir_ren", im_ren, 1);
    check_eq("post_redir_addr", im_addr, 32'h200);
    check_eq("post_redir_valid0", inst_valid, 0);
    next_cycle(); sample();
    check_eq("post_redir_valid1", inst_valid, 0);
    next_cycle(); sample();
    check_eq("redir_first_valid", inst_valid, 1);
    check_eq("redir_first_pc", inst_pc, 32'h200);
    check_eq("redir_first_inst", inst, mem_word(32'h200));

    // Back-to-back redirects: only the second stream survives.
    next_cycle(); redirect_valid = 1'b1; redirect_pc = 32'h40;
    next_cycle(); redirect_pc = 32'h80;
    next_cycle(); redirect_valid = 1'b0;
    sample();
    check_eq("b2b_ren", im_ren, 1);
    check_eq("b2b_addr", im_addr, 32'h80);
    next_cycle(); sample();
    next_cycle(); sample();
    check_eq("b2b_valid", inst_valid, 1);
    check_eq("b2b_pc", inst_pc, 32'h80);

    // fetch_en drop with a pending request: drain then resume sequentially.
    repeat (3) next_cycle();
    next_cycle(); fetch_en = 1'b0;
    sample();
    check_eq("en_drop_ren", im_ren, 0);
    check_eq("en_drop_head", inst_pc, 32'h90);
    next_cycle(); sample();
    check_eq("pending_delivered_valid", inst_valid, 1);
    check_eq("pending_delivered_pc", inst_pc, 32'h94);
    for (int k = 0; k < 3; k++) begin
      next_cycle(); sample();
      check_eq("drained_valid", inst_valid, 0);
      check_eq("drained_ren", im_ren, 0);
    end
    next_cycle(); fetch_en = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 5 && !found; k++) begin
      sample();
      if (im_ren) found = 1'b1;
      else next_cycle();
    end
    check_eq("reenable_ren_seen", {31'd0, found}, 1);
    check_eq("reenable_addr", im_addr, 32'h98);
    repeat (4) next_cycle();

    // Asynchronous reset mid-stream.
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check_eq("async_rst_ren", im_ren, 0);
    check_eq("async_rst_valid", inst_valid, 0);
    check_eq("async_rst_inst", inst, 0);
    check_eq("async_rst_pc", inst_pc, 0);
    check_eq("async_rst_addr", im_addr, RST_PC);
    repeat (2) next_cycle();
    reset = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      sample();
      if (inst_valid) found = 1'b1;
      else next_cycle();
    end
    check_eq("refetch_valid_seen", {31'd0, found}, 1);
    check_eq("refetch_pc", inst_pc, RST_PC);

    // PC wrap at the top of the address space.
    next_cycle(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF5;
    next_cycle(); redirect_valid = 1'b0;
    repeat (5) next_cycle();
    sample();
    check_eq("wrap_valid", inst_valid, 1);
    check_eq("wrap_pc", inst_pc, 32'h0);
    check_eq("wrap_inst", inst, 32'h1000_0000);

    // Random traffic against the stream model.
    pops_start = pops;
    for (int k = 0; k < 400; k++) begin
      next_cycle();
      fetch_en       = ($urandom_range(0, 7) != 0);
      inst_ready     = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ?
                       (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
    end
    next_cycle();
    redirect_valid = 1'b0; fetch_en = 1'b1; inst_ready = 1'b1;
    repeat (6) next_cycle();
    sample();
    check_eq("random_progress", {31'd0, (pops - pops_start) > 50}, 1);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
